rf_write_scheduler: RTL and testbench

//   Shares the register file's single write port between the in-order WB stage and the

---
 rtl/rf_sched_pkg.sv | 19 +
 rtl/rf_wb_fifo.sv | 60 ++++++
 rtl/rf_write_scheduler.sv | 150 +++++++++++++++
 tb/tb_rf_write_scheduler.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/rf_sched_pkg.sv
// Shared types and constants for the register-file write scheduler:
// the buffered write record and the starvation FSM states.
package rf_sched_pkg;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] val;
    } rf_wr_t;

    typedef enum logic {
        SERVE = 1'b0,
        FORCE = 1'b1
    } sched_state_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// Show-ahead synchronous FIFO of pending register-file writes. The head is
// visible combinationally so the write port can drain it in the same cycle.
module rf_wb_fifo
    import rf_sched_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  rf_wr_t                     wr_data,
    input  logic                       pop,
    output rf_wr_t                     head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int PTR_W = $clog2(DEPTH);

    rf_wr_t           mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // A push into a full FIFO is only taken when the head leaves in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        count_d  = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/rf_write_scheduler.sv
// Arbitrates the single register-file write port between WB and buffered
// MUL/DIV results, tracks pending multi-cycle destinations and flags ID hazards.
module rf_write_scheduler #(
    parameter int NUM_REGS     = 32,
    parameter int ADDR_W       = rf_sched_pkg::ADDR_W,
    parameter int DATA_W       = rf_sched_pkg::DATA_W,
    parameter int BUF_DEPTH    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wb_en,
    input  logic [ADDR_W-1:0]            wb_dest,
    input  logic [DATA_W-1:0]            wb_val,
    output logic                         wb_stall,
    input  logic                         md_issue,
    input  logic [ADDR_W-1:0]            md_issue_dest,
    input  logic                         md_valid,
    input  logic [ADDR_W-1:0]            md_dest,
    input  logic [DATA_W-1:0]            md_val,
    output logic                         md_ready,
    input  logic [ADDR_W-1:0]            id_src1,
    input  logic [ADDR_W-1:0]            id_src2,
    input  logic [ADDR_W-1:0]            id_dest,
    output logic                         id_hazard,
    output logic                         rf_we,
    output logic [ADDR_W-1:0]            rf_dest,
    output logic [DATA_W-1:0]            rf_val,
    output logic [$clog2(BUF_DEPTH):0]   buf_count
);

    localparam int STV_W = $clog2(STARVE_LIMIT) + 1;
    localparam logic [ADDR_W-1:0] ZERO = '0;

    rf_sched_pkg::rf_wr_t       head, push_data;
    rf_sched_pkg::sched_state_t state_q, state_d;
    logic                       fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic                       wb_sel, starve_cond;
    logic [NUM_REGS-1:0]        busy_q, busy_d;
    logic [STV_W-1:0]           starve_cnt_q, starve_cnt_d;
    logic                       wb_stall_q, wb_stall_d;

    assign md_ready  = !rst && !fifo_full;
    assign fifo_push = md_valid && md_ready && (md_dest != ZERO);
    assign push_data = '{dest: md_dest, val: md_val};
    assign wb_stall  = wb_stall_q;

    rf_wb_fifo #(
        .DEPTH   (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .wr_data (push_data),
        .pop     (fifo_pop),
        .head    (head),
        .count   (buf_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // WB owns the port unless it is frozen; otherwise the buffer head drains.
    always_comb begin
        wb_sel   = !wb_stall_q && wb_en;
        fifo_pop = 1'b0;
        rf_we    = 1'b0;
        rf_dest  = wb_dest;
        rf_val   = wb_val;
        if (!rst) begin
            if (wb_sel) begin
                rf_we = (wb_dest != ZERO);
            end else if (!fifo_empty) begin
                rf_we    = 1'b1;
                rf_dest  = head.dest;
                rf_val   = head.val;
                fifo_pop = 1'b1;
            end
        end
    end

    // A re-issue to a register whose result drains this cycle must stay busy.
    always_comb begin
        busy_d = busy_q;
        if (fifo_pop) begin
            busy_d[head.dest] = 1'b0;
        end
        if (md_issue && (md_issue_dest != ZERO)) begin
            busy_d[md_issue_dest] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    assign id_hazard = !rst && (((id_src1 != ZERO) && busy_q[id_src1]) ||
                                ((id_src2 != ZERO) && busy_q[id_src2]) ||
                                ((id_dest != ZERO) && busy_q[id_dest]));

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        starve_cond  = !fifo_empty && wb_en;
        case (state_q)
            rf_sched_pkg::SERVE: begin
                if (starve_cond) begin
                    if (starve_cnt_q == STV_W'(STARVE_LIMIT - 1)) begin
                        state_d      = rf_sched_pkg::FORCE;
                        starve_cnt_d = '0;
                    end else begin
                        starve_cnt_d = starve_cnt_q + 1'b1;
                    end
                end else begin
                    starve_cnt_d = '0;
                end
            end
            rf_sched_pkg::FORCE: begin
                state_d      = rf_sched_pkg::SERVE;
                starve_cnt_d = '0;
            end
            default: begin
                state_d      = rf_sched_pkg::SERVE;
                starve_cnt_d = '0;
            end
        endcase
        wb_stall_d = (state_d == rf_sched_pkg::FORCE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= rf_sched_pkg::SERVE;
            starve_cnt_q <= '0;
            wb_stall_q   <= 1'b0;
            busy_q       <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            wb_stall_q   <= wb_stall_d;
            busy_q       <= busy_d;
        end
    end

    a_wb_while_stalled: assert property (@(posedge clk) disable iff (rst)
        !(wb_en && wb_stall_q));

    a_issue_to_busy: assert property (@(posedge clk) disable iff (rst)
        !(md_issue && (md_issue_dest != ZERO) && busy_q[md_issue_dest] &&
          !(fifo_pop && (head.dest == md_issue_dest))));

    a_wb_to_busy: assert property (@(posedge clk) disable iff (rst)
        !(wb_en && (wb_dest != ZERO) && busy_q[wb_dest]));

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench: stimulus pushes expected register-file writes into a queue,
// a negedge monitor pops and compares each write the DUT presents.
module tb_rf_write_scheduler;

    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 32;
    localparam int BUF_DEPTH = 2;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        wb_en, wb_stall;
    logic [ADDR_W-1:0]           wb_dest;
    logic [DATA_W-1:0]           wb_val;
    logic                        md_issue, md_valid, md_ready;
    logic [ADDR_W-1:0]           md_issue_dest, md_dest;
    logic [DATA_W-1:0]           md_val;
    logic [ADDR_W-1:0]           id_src1, id_src2, id_dest;
    logic                        id_hazard, rf_we;
    logic [ADDR_W-1:0]           rf_dest;
    logic [DATA_W-1:0]           rf_val;
    logic [$clog2(BUF_DEPTH):0]  buf_count;

    typedef struct {
        logic [ADDR_W-1:0] d;
        logic [DATA_W-1:0] v;
    } wr_t;

    wr_t exp_q[$];
    int  compared   = 0;
    int  mismatched = 0;

    always #5 clk = ~clk;

    rf_write_scheduler #(
        .NUM_REGS      (32),
        .ADDR_W        (ADDR_W),
        .DATA_W        (DATA_W),
        .BUF_DEPTH     (BUF_DEPTH),
        .STARVE_LIMIT  (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_en         (wb_en),
        .wb_dest       (wb_dest),
        .wb_val        (wb_val),
        .wb_stall      (wb_stall),
        .md_issue      (md_issue),
        .md_issue_dest (md_issue_dest),
        .md_valid      (md_valid),
        .md_dest       (md_dest),
        .md_val        (md_val),
        .md_ready      (md_ready),
        .id_src1       (id_src1),
        .id_src2       (id_src2),
        .id_dest       (id_dest),
        .id_hazard     (id_hazard),
        .rf_we         (rf_we),
        .rf_dest       (rf_dest),
        .rf_val        (rf_val),
        .buf_count     (buf_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic expect_wr(input logic [ADDR_W-1:0] d, input logic [DATA_W-1:0] v);
        wr_t e;
        e.d = d;
        e.v = v;
        exp_q.push_back(e);
    endtask

    task automatic clr();
        wb_en = 1'b0; wb_dest = '0; wb_val = '0;
        md_issue = 1'b0; md_issue_dest = '0;
        md_valid = 1'b0; md_dest = '0; md_val = '0;
        id_src1 = '0; id_src2 = '0; id_dest = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write presented to the register file must match the queue head.
    initial begin : monitor
        wr_t e;
        forever begin
            @(negedge clk);
            if (!rst && rf_we) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_write: got r%0d=0x%0h, required no write (t=%0t)",
                             rf_dest, rf_val, $time);
                end else begin
                    e = exp_q.pop_front();
                    $display("write r%0d = 0x%0h (t=%0t)", rf_dest, rf_val, $time);
                    chk("rf_dest", 32'(rf_dest), 32'(e.d));
                    chk("rf_val", rf_val, e.v);
                end
            end
        end
    end

    initial begin
        clr();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rf_we",     32'(rf_we),     32'd0);
        chk("rst_md_ready",  32'(md_ready),  32'd0);
        chk("rst_id_hazard", 32'(id_hazard), 32'd0);
        chk("rst_buf_count", 32'(buf_count), 32'd0);
        chk("rst_wb_stall",  32'(wb_stall),  32'd0);
        rst = 1'b0;

        // Reset mid-run with two buffered results.
        tick(); clr(); md_issue = 1; md_issue_dest = 13;
        tick(); clr(); md_issue = 1; md_issue_dest = 14;
        md_valid = 1; md_dest = 13; md_val = 32'h1313;
        wb_en = 1; wb_dest = 1; wb_val = 32'h0101; expect_wr(1, 32'h0101);
        tick(); clr(); md_valid = 1; md_dest = 14; md_val = 32'h1414;
        wb_en = 1; wb_dest = 1; wb_val = 32'h0102; expect_wr(1, 32'h0102);
        #1 chk("t1_md_ready_1", 32'(md_ready), 32'd1);
        tick(); clr(); wb_en = 1; wb_dest = 1; wb_val = 32'h0103; expect_wr(1, 32'h0103);
        id_src1 = 13; id_src2 = 14;
        #1 chk("t1_buf_count_2", 32'(buf_count), 32'd2);
        chk("t1_md_ready_full", 32'(md_ready), 32'd0);
        chk("t1_hazard_pre", 32'(id_hazard), 32'd1);
        tick(); clr(); rst = 1; id_src1 = 13; id_src2 = 14;
        #1 chk("t1_rst_buf_count", 32'(buf_count), 32'd0);
        chk("t1_rst_rf_we", 32'(rf_we), 32'd0);
        chk("t1_rst_hazard", 32'(id_hazard), 32'd0);
        chk("t1_rst_wb_stall", 32'(wb_stall), 32'd0);
        tick(); rst = 0;
        #1 chk("t1_post_hazard", 32'(id_hazard), 32'd0);
        chk("t1_post_rf_we", 32'(rf_we), 32'd0);

        // Basic MUL result path and hazard clear.
        tick(); clr(); md_issue = 1; md_issue_dest = 5; id_src1 = 5;
        #1 chk("t2_hazard_before", 32'(id_hazard), 32'd0);
        tick(); clr(); id_src1 = 5; md_valid = 1; md_dest = 5; md_val = 32'h1234;
        expect_wr(5, 32'h1234);
        #1 chk("t2_hazard_busy", 32'(id_hazard), 32'd1);
        chk("t2_md_ready", 32'(md_ready), 32'd1);
        chk("t2_no_same_cycle_write", 32'(rf_we), 32'd0);
        tick(); clr(); id_src1 = 5;
        #1 chk("t2_rf_we", 32'(rf_we), 32'd1);
        chk("t2_hazard_during_write", 32'(id_hazard), 32'd1);
        tick(); clr(); id_src1 = 5;
        #1 chk("t2_hazard_cleared", 32'(id_hazard), 32'd0);

        // WB has priority over the buffered result.
        tick(); clr(); md_issue = 1; md_issue_dest = 7;
        tick(); clr(); wb_en = 1; wb_dest = 3; wb_val = 32'hAA; expect_wr(3, 32'hAA);
        md_valid = 1; md_dest = 7; md_val = 32'h77;
        tick(); clr(); wb_en = 1; wb_dest = 4; wb_val = 32'hBB; expect_wr(4, 32'hBB); id_dest = 7;
        #1 chk("t3_buf_count", 32'(buf_count), 32'd1);
        chk("t3_wb_wins", 32'(rf_dest), 32'd4);
        chk("t3_hazard_dest", 32'(id_hazard), 32'd1);
        tick(); clr(); expect_wr(7, 32'h77);
        #1 chk("t3_drain_dest", 32'(rf_dest), 32'd7);
        tick(); clr();
        #1 chk("t3_empty", 32'(buf_count), 32'd0);

        // Full buffer back-pressure.
        tick(); clr(); md_issue = 1; md_issue_dest = 10;
        tick(); clr(); md_issue = 1; md_issue_dest = 11;
        md_valid = 1; md_dest = 10; md_val = 32'h100;
        wb_en = 1; wb_dest = 1; wb_val = 32'h11; expect_wr(1, 32'h11);
        tick(); clr(); md_issue = 1; md_issue_dest = 12;
        md_valid = 1; md_dest = 11; md_val = 32'h101;
        wb_en = 1; wb_dest = 2; wb_val = 32'h22; expect_wr(2, 32'h22);
        #1 chk("t4_ready_one", 32'(md_ready), 32'd1);
        tick(); clr(); md_valid = 1; md_dest = 12; md_val = 32'h102;
        wb_en = 1; wb_dest = 1; wb_val = 32'h33; expect_wr(1, 32'h33);
        #1 chk("t4_count_full", 32'(buf_count), 32'd2);
        chk("t4_ready_full", 32'(md_ready), 32'd0);
        tick(); clr(); md_valid = 1; md_dest = 12; md_val = 32'h102; expect_wr(10, 32'h100);
        #1 chk("t4_count_still_full", 32'(buf_count), 32'd2);
        chk("t4_ready_pop_cycle", 32'(md_ready), 32'd0);
        tick(); clr(); md_valid = 1; md_dest = 12; md_val = 32'h102; expect_wr(11, 32'h101);
        #1 chk("t4_count_after_pop", 32'(buf_count), 32'd1);
        chk("t4_ready_again", 32'(md_ready), 32'd1);
        tick(); clr(); expect_wr(12, 32'h102);
        #1 chk("t4_third_accepted", 32'(buf_count), 32'd1);
        tick(); clr();
        #1 chk("t4_empty", 32'(buf_count), 32'd0);

        // Starvation: four blocked cycles force one drain slot.
        tick(); clr(); md_issue = 1; md_issue_dest = 20;
        tick(); clr(); md_valid = 1; md_dest = 20; md_val = 32'h2020;
        wb_en = 1; wb_dest = 21; wb_val = 32'h21; expect_wr(21, 32'h21);
        for (int i = 0; i < 4; i++) begin
            tick(); clr(); wb_en = 1; wb_dest = ADDR_W'(22 + i); wb_val = DATA_W'(32'h30 + i);
            expect_wr(ADDR_W'(22 + i), DATA_W'(32'h30 + i));
            #1 chk("t5_no_stall_yet", 32'(wb_stall), 32'd0);
            chk("t5_held", 32'(buf_count), 32'd1);
        end
        tick(); clr(); expect_wr(20, 32'h2020);
        #1 chk("t5_stall", 32'(wb_stall), 32'd1);
        chk("t5_forced_dest", 32'(rf_dest), 32'd20);
        tick(); clr(); wb_en = 1; wb_dest = 26; wb_val = 32'h26; expect_wr(26, 32'h26);
        #1 chk("t5_stall_released", 32'(wb_stall), 32'd0);
        chk("t5_drained", 32'(buf_count), 32'd0);

        // Register 0 handling and set-wins on the scoreboard.
        tick(); clr(); md_valid = 1; md_dest = 0; md_val = 32'hDEAD;
        wb_en = 1; wb_dest = 0; wb_val = 32'h55;
        #1 chk("t6_wb_r0_no_write", 32'(rf_we), 32'd0);
        chk("t6_ready", 32'(md_ready), 32'd1);
        tick(); clr();
        #1 chk("t6_r0_not_pushed", 32'(buf_count), 32'd0);
        chk("t6_r0_no_write", 32'(rf_we), 32'd0);
        tick(); clr(); md_issue = 1; md_issue_dest = 9;
        tick(); clr(); md_valid = 1; md_dest = 9; md_val = 32'h99;
        tick(); clr(); md_issue = 1; md_issue_dest = 9; expect_wr(9, 32'h99);
        #1 chk("t6_pop_r9", 32'(rf_dest), 32'd9);
        tick(); clr(); id_dest = 9;
        #1 chk("t6_set_wins", 32'(id_hazard), 32'd1);
        tick(); clr(); id_src2 = 9; md_valid = 1; md_dest = 9; md_val = 32'h999;
        #1 chk("t6_hazard_src2", 32'(id_hazard), 32'd1);
        tick(); clr(); id_src2 = 9; expect_wr(9, 32'h999);
        #1 chk("t6_hazard_write_cycle", 32'(id_hazard), 32'd1);
        tick(); clr(); id_src2 = 9;
        #1 chk("t6_hazard_clear", 32'(id_hazard), 32'd0);

        tick(); clr();
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
